// File: rtl/div_issue_stage.sv
// Issue/return stage in front of a combinational non-restoring array divider.
// Requests are queued in a 2-entry FIFO. The head is screened for divide-by-zero
// and quotient overflow when popped. Clean requests drive registered operands into
// the divider and wait LAT cycles before the quotient and remainder are captured.
// Responses come back in request order over a valid/ready handshake.
module div_issue_stage #(
  parameter int unsigned NX   = 3,  // must match the divider's Nx
  parameter int unsigned LAT  = 1,  // divider settle cycles, 1..15
  parameter int unsigned TAGW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2*NX-3:0]   req_dividend,
  input  logic [NX-2:0]     req_divisor,
  input  logic [TAGW-1:0]   req_tag,
  // divider operands and results
  output logic [NX-2:0]     div_D,
  output logic [2*NX-3:0]   div_R0,
  input  logic [NX-1:0]     div_Q,
  input  logic [2*NX-2:0]   div_R,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NX-1:0]     rsp_quot,
  output logic [2*NX-2:0]   rsp_rem,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [1:0]        rsp_err
);

  localparam int unsigned DW = 2 * NX - 2;  // dividend width
  localparam int unsigned VW = NX - 1;      // divisor width
  localparam int unsigned RW = 2 * NX - 1;  // remainder width

  localparam logic [3:0] LatCnt = 4'(LAT);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrZero = 2'b01;
  localparam logic [1:0] ErrOvf  = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   fifo_dvd_q [2];
  logic [VW-1:0]   fifo_dvs_q [2];
  logic [TAGW-1:0] fifo_tag_q [2];
  logic [1:0]      count_q, count_d;
  logic            wr_ptr_q, rd_ptr_q;
  logic            push, pop;
  state_e          state_q;

  // Ready depends only on the registered count, so a full FIFO never bypasses.
  assign req_ready = (count_q != 2'd2);
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == StIdle) && (count_q != 2'd0);

  // Occupancy next state; simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO occupancy and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO storage; contents are qualified by the count, so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dvd_q[wr_ptr_q] <= req_dividend;
      fifo_dvs_q[wr_ptr_q] <= req_divisor;
      fifo_tag_q[wr_ptr_q] <= req_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Head screening
  // ---------------------------------------------------------------------------
  logic [DW-1:0]   head_dvd;
  logic [VW-1:0]   head_dvs;
  logic [TAGW-1:0] head_tag;
  logic            head_zero, head_ovf;
  logic [1:0]      head_err;

  assign head_dvd = fifo_dvd_q[rd_ptr_q];
  assign head_dvs = fifo_dvs_q[rd_ptr_q];
  assign head_tag = fifo_tag_q[rd_ptr_q];

  // The quotient fits NX bits only if the dividend's upper part is below the divisor.
  // Divide-by-zero takes priority over overflow.
  always_comb begin
    head_zero = (head_dvs == '0);
    head_ovf  = ((head_dvd >> NX) >= {{(DW - VW){1'b0}}, head_dvs});
    head_err  = ErrNone;
    if (head_zero)     head_err = ErrZero;
    else if (head_ovf) head_err = ErrOvf;
  end

  // ---------------------------------------------------------------------------
  // Issue / settle / return FSM with registered outputs
  // ---------------------------------------------------------------------------
  logic [3:0]      settle_q;
  logic [VW-1:0]   div_d_q;
  logic [DW-1:0]   div_r0_q;
  logic            rsp_valid_q;
  logic [NX-1:0]   quot_q;
  logic [RW-1:0]   rem_q;
  logic [TAGW-1:0] tag_q;
  logic [1:0]      err_q;

  // Operands change only on a pop edge, which keeps the divider path multicycle-safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      settle_q    <= 4'd0;
      div_d_q     <= '0;
      div_r0_q    <= '0;
      rsp_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      err_q       <= ErrNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            div_d_q  <= head_dvs;
            div_r0_q <= head_dvd;
            tag_q    <= head_tag;
            if (head_err != ErrNone) begin
              // Rejected requests skip the divider and answer on the next cycle.
              quot_q      <= '1;
              rem_q       <= {{(RW - DW){1'b0}}, head_dvd};
              err_q       <= head_err;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              settle_q <= LatCnt;
              state_q  <= StWait;
            end
          end
        end
        StWait: begin
          if (settle_q == 4'd1) begin
            quot_q      <= div_Q;
            rem_q       <= div_R;
            err_q       <= ErrNone;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign div_D     = div_d_q;
  assign div_R0    = div_r0_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_quot  = quot_q;
  assign rsp_rem   = rem_q;
  assign rsp_tag   = tag_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/div_issue_stage.md
# div_issue_stage

Sequential issue/return stage that sits directly upstream of the combinational non-restoring array divider (parameter `Nx`). It accepts divide requests over a valid/ready handshake and buffers them in a 2-entry FIFO. It screens each request for divide-by-zero and quotient overflow, drives registered operands into the divider, waits a programmable settle time, then captures the quotient and remainder and returns them with a tag.

## Interface
- `NX`, default 3: must equal divider `Nx`. Divisor is NX-1 bits, dividend 2NX-2, quotient NX, remainder 2NX-1.
- `LAT`, default 1: divider settle cycles (multicycle path), legal 1..15.
- `TAGW`, default 4: request tag width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when both high.
- `req_dividend`  in  2NX-2  dividend.
- `req_divisor`  in  NX-1  divisor.
- `req_tag`  in  TAGW  returned unchanged.
- `div_D`  out  NX-1  registered divisor to divider `D`.
- `div_R0`  out  2NX-2  registered dividend to divider `R_0`.
- `div_Q`  in  NX  divider quotient `Q`.
- `div_R`  in  2NX-1  divider remainder `R_n1`.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when both high.
- `rsp_quot`  out  NX  quotient.
- `rsp_rem`  out  2NX-1  remainder.
- `rsp_tag`  out  TAGW  tag of request.
- `rsp_err`  out  2  00 ok, 01 divide-by-zero, 10 overflow.

## Operation
- **FIFO:** 2 entries of {dividend, divisor, tag}; 2-bit count; 1-bit rd/wr pointers wrap.
  - `req_ready = (count != 2)`, registered-count based; no same-cycle bypass when full.
  - Push and pop in the same cycle at count 1 leaves count 1.
- **Screening** happens at pop, on the FIFO head:
  - zero if divisor == 0;
  - overflow if (dividend >> NX) >= divisor, i.e. quotient does not fit NX bits;
  - zero has priority over overflow.
- **FSM states:** IDLE, WAIT, RESP.
  - **IDLE:** if count != 0, pop the head and load `div_D`/`div_R0` and the tag register.
    - Error → RESP with `rsp_quot` = all ones, `rsp_rem` = zero-extended dividend, `rsp_err` set.
    - No error → WAIT with settle counter = LAT.
  - **WAIT:** counter decrements each cycle. When counter == 1, on that edge capture `div_Q` → `rsp_quot`, `div_R` → `rsp_rem`, `rsp_err` = 00, and go to RESP.
  - **RESP:** `rsp_valid` = 1; all `rsp_*` are stable until `rsp_valid && rsp_ready`, then IDLE.
- `div_D`/`div_R0` hold their value outside pops. They change only at a pop edge, never during WAIT.
- FIFO accepts requests in every state while not full.
- Responses return in request order.

## Timing
- **Reset (async assert, sync-release use):**
  - state IDLE, count 0, pointers 0;
  - `req_ready` = 1;
  - `rsp_valid` = 0;
  - `rsp_quot`, `rsp_rem`, `rsp_tag`, `rsp_err`, `div_D`, `div_R0` = 0.
- **Latency**, with acceptance at edge t into an empty FIFO and idle FSM:
  - pop at edge t+1;
  - error: `rsp_valid` high after edge t+1;
  - ok: capture at edge t+1+LAT, `rsp_valid` high after edge t+1+LAT (LAT=1: 2 cycles after acceptance).
- **Throughput:** one response per LAT+2 cycles when `rsp_ready` is held high; one per 2 cycles for error requests.
- **`req_valid` while `req_ready` = 0:** request is ignored; the upstream holds it.
- **Reset mid-WAIT or mid-RESP:** the in-flight request and FIFO contents are dropped; `rsp_valid` drops asynchronously.
- **`rsp_ready` asserted without `rsp_valid`:** no effect.

## Test plan
Bench instantiates the real divider with NX=3, LAT=1; a golden model compares every response.
- **Ok request:** dividend 13, divisor 2, tag 5 → `rsp_quot` 6, `rsp_rem` 1, `rsp_err` 00, tag 5, `rsp_valid` 2 cycles after acceptance. Also dividend 11, divisor 3 → quotient 3, remainder 2.
- **Divide-by-zero:** dividend 9, divisor 0 → `rsp_err` 01, `rsp_quot` 7, `rsp_rem` 9, `rsp_valid` 1 cycle after acceptance. Dividend 15, divisor 0 → `rsp_err` 01 (zero wins over overflow).
- **Overflow:** dividend 15, divisor 1 → `rsp_err` 10, `rsp_quot` 7, `rsp_rem` 15. Dividend 7, divisor 1 → ok, quotient 7, remainder 0.
- **Back-pressure:** hold `rsp_ready` low and send 4 back-to-back requests.
  - 1st goes in flight, the next 2 fill the FIFO.
  - `req_ready` = 0 with the 4th held; the 4th is accepted only after the first response handshake.
  - All 4 return in order with correct tags, and `rsp_*` stay stable while stalled.
- **Reset mid-operation:** assert `rst_n` low during WAIT with 2 entries queued → next cycle `rsp_valid` 0, `req_ready` 1. After release, a fresh request completes normally and no stale responses appear.
- **Random soak, LAT=3:** 10k random requests with random `rsp_ready` → all results match the model, `div_D`/`div_R0` never change in WAIT, no loss or duplication.
